// File: rtl/mem_access_stall.sv
// rtl/mem_access_stall.sv - memory stage with data-bus handshake, wait counting, timeout and misalignment abort
module mem_access_stall #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      ir_src_mem,
  input  logic            mem_oe,
  input  logic            mem_wr,
  input  logic [XLEN-1:0] pc_mem_next,
  input  logic [XLEN-1:0] ir_mem_next,
  input  logic [XLEN-1:0] y_mem_next,
  input  logic [XLEN-1:0] st_mem_next,
  output logic [XLEN-1:0] pc_wb_next,
  output logic [XLEN-1:0] ir_wb_next,
  output logic [XLEN-1:0] y_wb_next,
  output logic [XLEN-1:0] mem_rd,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            mem_stall,
  output logic            mem_fault
);

  // IR source select encodings shared with the decode stage
  localparam logic [1:0] IR_SRC_DATA   = 2'd0;
  localparam logic [1:0] IR_SRC_NOP    = 2'd1;
  localparam logic [1:0] IR_SRC_EXCEPT = 2'd2;

  // Canonical bubble and exception-branch instruction words
  localparam logic [XLEN-1:0] INST_NOP        = XLEN'(32'h0000_0013);
  localparam logic [XLEN-1:0] INST_BNE_EXCEPT = XLEN'(32'h0000_1063);

  localparam logic [7:0] MAX_WAIT_CNT = 8'(MAX_WAIT);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t          r_state;
  logic [7:0]      r_wait_cnt;

  logic [XLEN-1:0] r_pc_q;
  logic [XLEN-1:0] r_ir_q;
  logic [XLEN-1:0] r_y_q;
  logic [XLEN-1:0] r_st_q;
  logic            r_oe_q;
  logic            r_wr_q;

  logic            w_access;
  logic            w_aligned;
  logic            w_pending;
  logic            w_misaligned;
  logic            w_busy;
  logic            w_timeout;
  logic            w_complete;
  logic            w_load;

  // A memory instruction is only acted on when the IR source says the
  // stage holds real data; otherwise it is a bubble or an exception slot.
  assign w_access     = (r_oe_q | r_wr_q) && (ir_src_mem == IR_SRC_DATA);
  assign w_aligned    = (r_y_q[1:0] == 2'b00);
  assign w_busy       = (r_state == ST_BUSY);

  // Every completion or abort is a non-stall cycle, so the stage always
  // reloads on the following edge; an IDLE pending access therefore always
  // belongs to freshly loaded contents and a finished access never reissues.
  assign w_pending    = !w_busy && w_access && w_aligned;
  assign w_misaligned = !w_busy && w_access && !w_aligned;

  // Ack on the last allowed BUSY cycle wins over the timeout.
  assign w_timeout    = w_busy && !dmem_ack && (r_wait_cnt == MAX_WAIT_CNT);
  assign w_complete   = (w_pending || w_busy) && dmem_ack;

  // Bus side: held for the whole access even if the IR source changes
  // mid-BUSY, so the memory never sees a request withdrawn before ack.
  assign dmem_req   = w_pending || w_busy;
  assign dmem_we    = r_wr_q;
  assign dmem_addr  = r_y_q;
  assign dmem_wdata = r_st_q;

  assign mem_stall  = (w_pending && !dmem_ack) || (w_busy && !dmem_ack && !w_timeout);
  assign mem_fault  = w_misaligned || w_timeout;
  assign mem_rd     = w_complete ? dmem_rdata : '0;

  assign pc_wb_next = r_pc_q;
  assign y_wb_next  = r_y_q;

  assign w_load     = !mem_stall;

  // Writeback instruction select: a fault always turns into the exception branch
  always_comb begin
    ir_wb_next = 'x;
    if (mem_fault) begin
      ir_wb_next = INST_BNE_EXCEPT;
    end else begin
      case (ir_src_mem)
        IR_SRC_EXCEPT: ir_wb_next = INST_BNE_EXCEPT;
        IR_SRC_NOP:    ir_wb_next = INST_NOP;
        IR_SRC_DATA:   ir_wb_next = r_ir_q;
        default:       ir_wb_next = 'x;
      endcase
    end
  end

  // Stage registers: advance whenever the stage is not stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc_q <= '0;
      r_ir_q <= INST_NOP;
      r_y_q  <= '0;
      r_st_q <= '0;
      r_oe_q <= 1'b0;
      r_wr_q <= 1'b0;
    end else if (w_load) begin
      r_pc_q <= pc_mem_next;
      r_ir_q <= ir_mem_next;
      r_y_q  <= y_mem_next;
      r_st_q <= st_mem_next;
      r_oe_q <= mem_oe;
      r_wr_q <= mem_wr;
    end
  end

  // Access FSM: IDLE issues, BUSY waits for ack or gives up at MAX_WAIT
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pending && !dmem_ack) begin
            r_state    <= ST_BUSY;
            r_wait_cnt <= 8'd1;
          end else begin
            r_wait_cnt <= 8'd0;
          end
        end
        ST_BUSY: begin
          if (dmem_ack || w_timeout) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 8'd0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_wait_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stall.sv
// tb/tb_mem_access_stall.sv - directed vectors for mem_access_stall
module tb_mem_access_stall;

  localparam int XLEN = 32;

  localparam logic [1:0]  SRC_DATA   = 2'd0;
  localparam logic [1:0]  SRC_NOP    = 2'd1;
  localparam logic [1:0]  SRC_EXCEPT = 2'd2;
  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [31:0] BNE_EXC    = 32'h0000_1063;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      ir_src_mem;
  logic            mem_oe, mem_wr;
  logic [XLEN-1:0] pc_mem_next, ir_mem_next, y_mem_next, st_mem_next;
  logic [XLEN-1:0] pc_wb_next, ir_wb_next, y_wb_next, mem_rd;
  logic            dmem_req, dmem_we;
  logic [XLEN-1:0] dmem_addr, dmem_wdata;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_rdata;
  logic            mem_stall, mem_fault;

  int n_vec = 0;
  int n_err = 0;

  mem_access_stall #(.XLEN(XLEN), .MAX_WAIT(15)) dut (
    .clk(clk), .rst_n(rst_n), .ir_src_mem(ir_src_mem),
    .mem_oe(mem_oe), .mem_wr(mem_wr),
    .pc_mem_next(pc_mem_next), .ir_mem_next(ir_mem_next),
    .y_mem_next(y_mem_next), .st_mem_next(st_mem_next),
    .pc_wb_next(pc_wb_next), .ir_wb_next(ir_wb_next),
    .y_wb_next(y_wb_next), .mem_rd(mem_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Present an instruction on the stage inputs
  task automatic present(input logic oe, input logic wr, input logic [31:0] pc,
                         input logic [31:0] ir, input logic [31:0] y, input logic [31:0] st);
    mem_oe = oe; mem_wr = wr;
    pc_mem_next = pc; ir_mem_next = ir; y_mem_next = y; st_mem_next = st;
  endtask

  task automatic bubble();
    present(1'b0, 1'b0, 32'hAAAA, NOP, 32'h0, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; ir_src_mem = SRC_DATA; dmem_ack = 1'b0; dmem_rdata = '0;
    bubble();
    step(); step();

    // reset state
    check("rst_req_stall_fault", {dmem_req, mem_stall, mem_fault}, 3'b000);
    check("rst_mem_rd", mem_rd, 32'h0);
    check("rst_ir_wb", ir_wb_next, NOP);
    check("rst_pc_wb", pc_wb_next, 32'h0);
    rst_n = 1'b1;

    // zero-wait load
    present(1'b1, 1'b0, 32'h40, 32'h1111_1111, 32'h100, 32'h0);
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    step(); bubble(); #1;
    check("zw_req_we", {dmem_req, dmem_we}, 2'b10);
    check("zw_addr", dmem_addr, 32'h100);
    check("zw_mem_rd", mem_rd, 32'hDEAD_BEEF);
    check("zw_stall_fault", {mem_stall, mem_fault}, 2'b00);
    check("zw_ir_wb", ir_wb_next, 32'h1111_1111);
    check("zw_pc_y", {pc_wb_next, y_wb_next}, {32'h40, 32'h100});
    step();
    check("zw_after_req", dmem_req, 1'b0);
    check("zw_after_rd", mem_rd, 32'h0);
    dmem_ack = 1'b0;

    // three-wait store, stage must hold while stalled
    present(1'b0, 1'b1, 32'h80, 32'h2222_2222, 32'h204, 32'h55AA);
    step(); bubble(); #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("st_w%0d_ctl", i), {dmem_req, dmem_we, mem_stall, mem_fault}, 4'b1110);
      check($sformatf("st_w%0d_bus", i), {dmem_addr, dmem_wdata}, {32'h204, 32'h55AA});
      check($sformatf("st_w%0d_pc", i), pc_wb_next, 32'h80);
      step();
    end
    dmem_ack = 1'b1; #1;
    check("st_ack_ctl", {dmem_req, dmem_we, mem_stall, mem_fault}, 4'b1100);
    check("st_ack_ir", ir_wb_next, 32'h2222_2222);
    step(); dmem_ack = 1'b0; #1;
    check("st_done_req", dmem_req, 1'b0);
    check("st_done_pc", pc_wb_next, 32'hAAAA);

    // timeout after 15 BUSY cycles
    present(1'b1, 1'b0, 32'hC0, 32'h3333_3333, 32'h300, 32'h0);
    step(); bubble(); #1;
    for (int k = 0; k < 15; k++) begin
      check($sformatf("to_c%0d", k), {dmem_req, mem_stall, mem_fault}, 3'b110);
      step();
    end
    check("to_fault", {dmem_req, mem_stall, mem_fault}, 3'b101);
    check("to_ir_wb", ir_wb_next, BNE_EXC);
    check("to_rd", mem_rd, 32'h0);
    step();
    check("to_after", {dmem_req, mem_stall, mem_fault}, 3'b000);

    // ack on the timeout cycle wins
    present(1'b1, 1'b0, 32'hC4, 32'h3434_3434, 32'h304, 32'h0);
    step(); bubble(); #1;
    for (int k = 0; k < 15; k++) step();
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D; #1;
    check("tw_ctl", {dmem_req, mem_stall, mem_fault}, 3'b100);
    check("tw_rd", mem_rd, 32'hCAFE_F00D);
    check("tw_ir", ir_wb_next, 32'h3434_3434);
    step(); dmem_ack = 1'b0; #1;
    check("tw_after", dmem_req, 1'b0);

    // misaligned load
    present(1'b1, 1'b0, 32'hD0, 32'h4444_0000, 32'h102, 32'h0);
    step(); bubble(); #1;
    check("mis_ctl", {dmem_req, mem_stall, mem_fault}, 3'b001);
    check("mis_ir", ir_wb_next, BNE_EXC);
    step();
    check("mis_after", {dmem_req, mem_fault}, 2'b00);

    // IR source exception on a bubble
    ir_src_mem = SRC_EXCEPT; #1;
    check("exc_ir", ir_wb_next, BNE_EXC);
    check("exc_req", dmem_req, 1'b0);
    ir_src_mem = SRC_DATA;

    // squash to NOP mid-BUSY: request held until ack at wait 4
    present(1'b1, 1'b0, 32'hE0, 32'h4444_4444, 32'h400, 32'h0);
    step(); bubble(); #1;
    step(); step();
    ir_src_mem = SRC_NOP; #1;
    check("sq_w2", {dmem_req, mem_stall}, 2'b11);
    check("sq_w2_ir", ir_wb_next, NOP);
    step();
    check("sq_w3", {dmem_req, mem_stall}, 2'b11);
    step();
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678; #1;
    check("sq_w4", {dmem_req, mem_stall, mem_fault}, 3'b100);
    check("sq_w4_ir", ir_wb_next, NOP);
    check("sq_w4_rd", mem_rd, 32'h1234_5678);
    step(); dmem_ack = 1'b0; ir_src_mem = SRC_DATA; #1;
    check("sq_after", dmem_req, 1'b0);

    // reset while BUSY
    present(1'b1, 1'b0, 32'hF0, 32'h5555_5555, 32'h500, 32'h0);
    step(); bubble(); #1;
    step(); step();
    check("rb_w2", {dmem_req, mem_stall}, 2'b11);
    rst_n = 1'b0;
    step();
    check("rb_ctl", {dmem_req, mem_stall, mem_fault}, 3'b000);
    check("rb_ir", ir_wb_next, NOP);
    check("rb_pc", pc_wb_next, 32'h0);
    rst_n = 1'b1;
    step();
    check("rb_idle", {dmem_req, mem_stall}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_stall.md
MEM_ACCESS_STALL -- requirements
Module: mem_access_stall

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the datapath width of pc, ir, y, st, dmem_addr, dmem_wdata, dmem_rdata and mem_rd (minimum 32).
REQ-002 Parameter MAX_WAIT, default 15, SHALL set the maximum number of BUSY cycles before a timeout abort (range 1..255).
REQ-003 Clocking and reset SHALL be one clock and a synchronous, active-low reset: clk (rising edge) and rst_n.
REQ-004 Ports SHALL be:
 clk  in  1  clock
 rst_n  in  1  synchronous active-low reset
 ir_src_mem  in  2  IR source select, encodings from defines.v
 mem_oe, mem_wr  in  1 each  load / store request for the incoming instruction
 pc_mem_next, ir_mem_next, y_mem_next, st_mem_next  in  XLEN each  stage inputs
 pc_wb_next, ir_wb_next, y_wb_next, mem_rd  out  XLEN each  values to writeback
 dmem_req, dmem_we  out  1 each  memory request / write qualifier
 dmem_addr, dmem_wdata  out  XLEN each  memory address / store data
 dmem_ack  in  1  memory completion
 dmem_rdata  in  XLEN  memory read data
 mem_stall  out  1  upstream hold
 mem_fault  out  1  one-cycle abort pulse

Function
REQ-005 Stage registers pc_q, ir_q, y_q, st_q, oe_q and wr_q SHALL load from their *_next inputs on every rising edge where mem_stall=0, and SHALL hold otherwise.
REQ-006 The FSM SHALL have two states: IDLE and BUSY.
REQ-007 An access SHALL be pending in IDLE when (oe_q|wr_q)=1, ir_src_mem=IR_SRC_DATA, y_q[1:0]=0, and no completion has occurred for the current ir_q.
REQ-008 While an access is pending or the FSM is in BUSY, dmem_req SHALL be 1, dmem_we=wr_q, dmem_addr=y_q, and dmem_wdata=st_q.
REQ-009 In IDLE with a pending access and dmem_ack=1, the access SHALL complete in zero wait cycles, with mem_stall=0 and the FSM remaining in IDLE.
REQ-010 In IDLE with a pending access and dmem_ack=0, mem_stall SHALL be 1 and the FSM SHALL move to BUSY with wait_cnt=1.
REQ-011 In BUSY, mem_stall SHALL be 1 and wait_cnt SHALL increment each cycle until dmem_ack=1; on ack, mem_stall=0 and the FSM SHALL return to IDLE with wait_cnt cleared.
REQ-012 mem_rd SHALL equal dmem_rdata in the completion cycle (combinational) and SHALL be 0 in all other cycles.
REQ-013 In BUSY, if wait_cnt=MAX_WAIT and dmem_ack=0, the block SHALL abort: mem_fault=1 for one cycle, mem_stall=0, and the FSM SHALL return to IDLE; an ack arriving on that same cycle SHALL win (normal completion, no fault).
REQ-014 A misaligned access (oe_q|wr_q, IR_SRC_DATA, y_q[1:0]!=0) SHALL NOT assert dmem_req, and SHALL produce mem_fault=1 and mem_stall=0 in that cycle.
REQ-015 ir_wb_next priority SHALL be:
 - mem_fault=1 -> INST_BNE_EXCEPT
 - else IR_SRC_EXCEPT -> INST_BNE_EXCEPT
 - else IR_SRC_NOP -> INST_NOP
 - else IR_SRC_DATA -> ir_q
 - else all-X
REQ-016 A change of ir_src_mem to a non-DATA value while in BUSY SHALL NOT cancel the bus request; the access SHALL complete or time out, and only ir_wb_next SHALL follow REQ-015.
REQ-017 pc_wb_next SHALL be pc_q and y_wb_next SHALL be y_q at all times.
REQ-018 A stalled completion SHALL NOT reissue: after completion or abort, dmem_req SHALL remain 0 until new stage contents are loaded.

Reset
REQ-019 With rst_n=0 at a rising edge, the block SHALL clear pc_q, y_q, st_q, oe_q, wr_q and wait_cnt to 0, set ir_q=INST_NOP, and enter IDLE; reset SHALL override BUSY mid-access.
REQ-020 After reset, outputs SHALL be dmem_req=0, mem_stall=0, mem_fault=0 and mem_rd=0.

Verification
REQ-021 Zero-wait load: oe, y=0x100, ack in the same cycle, rdata=0xDEADBEEF -> mem_rd=0xDEADBEEF, mem_stall never asserted.
REQ-022 3-wait store: wr, y=0x204, st=0x55AA, ack after 3 cycles -> dmem_req high 4 cycles with dmem_we=1 and wdata=0x55AA, mem_stall high 3 cycles, stage registers hold.
REQ-023 Timeout: MAX_WAIT=15, no ack -> mem_fault pulse on BUSY cycle 15, ir_wb_next=INST_BNE_EXCEPT, dmem_req drops the next cycle.
REQ-024 Misaligned: oe, y=0x102 -> dmem_req=0, mem_fault=1, ir_wb_next=INST_BNE_EXCEPT, no stall.
REQ-025 Squash mid-BUSY: ir_src_mem set to NOP at wait 2, ack at wait 4 -> request held until ack, ir_wb_next=INST_NOP.
REQ-026 Reset in BUSY: rst_n=0 at wait 2 -> next cycle dmem_req=0, mem_stall=0, ir_wb_next=INST_NOP with IR_SRC_DATA.
